// File: rtl/conv_pkg.sv
// Shared constants, derived widths and state encoding for the 5x5 convolution
// frame scheduler and its raster counter.
package conv_pkg;
    localparam int DW  = 8;
    localparam int K   = 5;
    localparam int IMG = 32;
    localparam int OUT = IMG - K + 1;
    localparam int KK  = K * K;

    localparam int WAW = $clog2(KK);
    localparam int CW  = $clog2(IMG);
    localparam int OW  = $clog2(OUT * OUT);

    // Terminal values typed to their counter widths so compares stay width-exact
    localparam logic [CW-1:0]  POS_LAST = CW'(IMG - 1);
    localparam logic [CW-1:0]  WIN_MIN  = CW'(K - 1);
    localparam logic [WAW-1:0] W_LAST   = WAW'(KK - 1);
    localparam logic [OW-1:0]  IDX_LAST = OW'(OUT * OUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        READY,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/conv_frame_scheduler_if.sv
// Host/stream-side bundle of the frame scheduler: weight write port, frame
// start, pixel handshake and window/status outputs.
interface conv_frame_scheduler_if;
    import conv_pkg::*;

    logic           i_w_valid;
    logic [DW-1:0]  i_w;
    logic           o_w_wr_en;
    logic [WAW-1:0] o_w_addr;
    logic [DW-1:0]  o_w;
    logic           o_w_loaded;
    logic           i_start;
    logic           i_pix_valid;
    logic           o_pix_ready;
    logic [CW-1:0]  o_row;
    logic [CW-1:0]  o_col;
    logic           o_win_valid;
    logic [OW-1:0]  o_out_idx;
    logic           o_busy;
    logic           o_done;

    modport master (
        output i_w_valid, i_w, i_start, i_pix_valid,
        input  o_w_wr_en, o_w_addr, o_w, o_w_loaded, o_pix_ready,
               o_row, o_col, o_win_valid, o_out_idx, o_busy, o_done
    );

    modport slave (
        input  i_w_valid, i_w, i_start, i_pix_valid,
        output o_w_wr_en, o_w_addr, o_w, o_w_loaded, o_pix_ready,
               o_row, o_col, o_win_valid, o_out_idx, o_busy, o_done
    );
endinterface

// File: rtl/conv_raster_cnt.sv
// Raster-order row/column counter with clear and enable; flags the final
// frame position and whether a full KxK window ends at the current position.
module conv_raster_cnt
    import conv_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_row,
    output logic [CW-1:0] o_col,
    output logic          o_last,
    output logic          o_win
);
    logic [CW-1:0] row_reg;
    logic [CW-1:0] col_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            row_reg <= '0;
            col_reg <= '0;
        end else if (i_en) begin
            if (col_reg == POS_LAST) begin
                col_reg <= '0;
                row_reg <= (row_reg == POS_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    assign o_row  = row_reg;
    assign o_col  = col_reg;
    assign o_last = (row_reg == POS_LAST) && (col_reg == POS_LAST);
    assign o_win  = (row_reg >= WIN_MIN) && (col_reg >= WIN_MIN);
endmodule

// File: rtl/conv_frame_scheduler.sv
// Convolution front-end sequencer: loads the kernel weight bank, then paces
// one raster pass over the input frame and flags valid window positions.
module conv_frame_scheduler
    import conv_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    conv_frame_scheduler_if.slave  bus
);
    state_t         state_reg, state_next;
    logic [WAW-1:0] w_cnt_reg;
    logic           w_wr_en_reg;
    logic [WAW-1:0] w_addr_reg;
    logic [DW-1:0]  w_data_reg;
    logic           w_loaded_reg;
    logic [CW-1:0]  row_out_reg;
    logic [CW-1:0]  col_out_reg;
    logic           win_valid_reg;
    logic [OW-1:0]  out_idx_reg;

    logic           w_accept, w_restart, load_done, run_start;
    logic           pix_ready, pix_accept;
    logic [CW-1:0]  cnt_row, cnt_col;
    logic           cnt_last, cnt_win;

    assign pix_ready  = (state_reg == RUN);
    assign pix_accept = pix_ready && bus.i_pix_valid;

    always_comb begin
        state_next = state_reg;
        w_accept   = 1'b0;
        w_restart  = 1'b0;
        load_done  = 1'b0;
        run_start  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.i_w_valid) begin
                    w_accept   = 1'b1;
                    w_restart  = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (bus.i_w_valid) begin
                    w_accept = 1'b1;
                    if (w_cnt_reg == W_LAST) begin
                        load_done  = 1'b1;
                        state_next = READY;
                    end
                end
            end
            READY: begin
                // A start in the same cycle as a weight word wins; the word is dropped
                if (bus.i_start) begin
                    run_start  = 1'b1;
                    state_next = RUN;
                end else if (bus.i_w_valid) begin
                    w_accept   = 1'b1;
                    w_restart  = 1'b1;
                    state_next = LOAD;
                end
            end
            RUN: begin
                if (pix_accept && cnt_last) state_next = DONE;
            end
            DONE:    state_next = READY;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg     <= IDLE;
            w_cnt_reg     <= '0;
            w_wr_en_reg   <= 1'b0;
            w_addr_reg    <= '0;
            w_data_reg    <= '0;
            w_loaded_reg  <= 1'b0;
            row_out_reg   <= '0;
            col_out_reg   <= '0;
            win_valid_reg <= 1'b0;
            out_idx_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            w_wr_en_reg <= w_accept;
            if (w_accept) begin
                w_addr_reg <= w_restart ? '0 : w_cnt_reg;
                w_data_reg <= bus.i_w;
                if (w_restart)      w_cnt_reg <= WAW'(1);
                else if (load_done) w_cnt_reg <= '0;
                else                w_cnt_reg <= w_cnt_reg + 1'b1;
            end
            if (w_restart)      w_loaded_reg <= 1'b0;
            else if (load_done) w_loaded_reg <= 1'b1;

            if (pix_accept) begin
                row_out_reg   <= cnt_row;
                col_out_reg   <= cnt_col;
                win_valid_reg <= cnt_win;
            end else begin
                win_valid_reg <= 1'b0;
            end

            // Index advances after each window pulse and parks on the last output
            if (run_start)
                out_idx_reg <= '0;
            else if (win_valid_reg && (out_idx_reg != IDX_LAST))
                out_idx_reg <= out_idx_reg + 1'b1;
        end
    end

    conv_raster_cnt u_raster (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (run_start),
        .i_en    (pix_accept),
        .o_row   (cnt_row),
        .o_col   (cnt_col),
        .o_last  (cnt_last),
        .o_win   (cnt_win)
    );

    assign bus.o_w_wr_en   = w_wr_en_reg;
    assign bus.o_w_addr    = w_addr_reg;
    assign bus.o_w         = w_data_reg;
    assign bus.o_w_loaded  = w_loaded_reg;
    assign bus.o_pix_ready = pix_ready;
    assign bus.o_row       = row_out_reg;
    assign bus.o_col       = col_out_reg;
    assign bus.o_win_valid = win_valid_reg;
    assign bus.o_out_idx   = out_idx_reg;
    assign bus.o_busy      = (state_reg == RUN);
    assign bus.o_done      = (state_reg == DONE);
endmodule

// File: tb/tb_conv_frame_scheduler.sv
// Scoreboard bench for conv_frame_scheduler: stimulus pushes expected weight
// writes, window events and done pulses; a negedge monitor pops and compares.
module tb_conv_frame_scheduler;
    import conv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv_frame_scheduler_if bus ();

    conv_frame_scheduler dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int chk_cnt = 0;
    int pass_cnt = 0;
    int acc_cnt = 0;
    int win_cnt = 0;
    int done_seen = 0;
    int exp_done = 0;

    logic [12:0] wq[$];    // {addr, data}
    logic [19:0] winq[$];  // {row, col, out_idx}

    bit            prev_idle = 1'b0;
    logic [CW-1:0] prev_row = '0;
    logic [CW-1:0] prev_col = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compares DUT outputs against the scoreboard on every falling edge
    always @(negedge clk) begin
        if (bus.o_w_wr_en) begin
            if (wq.size() == 0) begin
                chk_cnt++;
                $display("FAIL w_unexpected: strobe addr %0d data %0d with nothing pending",
                         bus.o_w_addr, bus.o_w);
            end else begin
                check("w_write", 64'({bus.o_w_addr, bus.o_w}), 64'(wq.pop_front()));
            end
        end
        if (bus.o_win_valid) begin
            win_cnt++;
            if (winq.size() == 0) begin
                chk_cnt++;
                $display("FAIL win_unexpected: window at (%0d,%0d) idx %0d with nothing pending",
                         bus.o_row, bus.o_col, bus.o_out_idx);
            end else begin
                check("win_pos_idx", 64'({bus.o_row, bus.o_col, bus.o_out_idx}), 64'(winq.pop_front()));
            end
        end
        if (bus.o_done) begin
            done_seen++;
            check("done_expected", 64'(exp_done > 0), 64'(1));
            if (exp_done > 0) exp_done--;
        end
        if (prev_idle)
            check("idle_hold", 64'({bus.o_win_valid, bus.o_row, bus.o_col}),
                  64'({1'b0, prev_row, prev_col}));
        prev_idle = rst_n && bus.o_pix_ready && !bus.i_pix_valid;
        prev_row  = bus.o_row;
        prev_col  = bus.o_col;
        if (rst_n && bus.o_pix_ready && bus.i_pix_valid) acc_cnt++;
    end

    task automatic load_weights(input int base, input int gap);
        for (int i = 0; i < KK; i++) begin
            bus.i_w_valid = 1'b1;
            bus.i_w = 8'(base + i);
            wq.push_back({5'(i), 8'(base + i)});
            @(posedge clk); #1;
            bus.i_w_valid = 1'b0;
            if (i == 0) check("loaded_clear", 64'(bus.o_w_loaded), 64'(0));
            if (i == KK - 1) check("loaded_set", 64'(bus.o_w_loaded), 64'(1));
            if (gap > 0) repeat (gap) begin @(posedge clk); #1; end
        end
        repeat (3) begin @(posedge clk); #1; end
        check("load_q_drained", 64'(wq.size()), 64'(0));
    endtask

    task automatic push_windows();
        int idx = 0;
        for (int r = K - 1; r < IMG; r++)
            for (int c = K - 1; c < IMG; c++) begin
                winq.push_back({5'(r), 5'(c), 10'(idx)});
                idx++;
            end
    endtask

    task automatic start_pulse(input bit expect_run);
        bus.i_start = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        check("start_latency", 64'({bus.o_pix_ready, bus.o_busy}), expect_run ? 64'(3) : 64'(0));
    endtask

    task automatic run_frame(input bit bp, input bit noise);
        int start_done;
        bit ok;
        ok = 1'b0;
        start_done = done_seen;
        acc_cnt = 0;
        win_cnt = 0;
        exp_done++;
        push_windows();
        start_pulse(1'b1);
        for (int cyc = 0; cyc < 6000; cyc++) begin
            bus.i_pix_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (noise) begin
                bus.i_start   = 1'($urandom_range(0, 1));
                bus.i_w_valid = 1'($urandom_range(0, 1));
                bus.i_w       = 8'($urandom);
            end
            @(posedge clk); #1;
            if (done_seen != start_done) begin
                ok = 1'b1;
                break;
            end
        end
        bus.i_pix_valid = 1'b0;
        bus.i_start = 1'b0;
        bus.i_w_valid = 1'b0;
        check("frame_done_seen", 64'(ok), 64'(1));
        check("frame_accepts", 64'(acc_cnt), 64'(IMG * IMG));
        check("frame_windows", 64'(win_cnt), 64'(OUT * OUT));
        check("frame_win_q_drained", 64'(winq.size()), 64'(0));
        check("post_frame_ready", 64'({bus.o_busy, bus.o_pix_ready, bus.o_done, bus.o_w_loaded}),
              64'(4'b0001));
        check("post_frame_idx", 64'(bus.o_out_idx), 64'(OUT * OUT - 1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.i_w_valid = 1'b0;
        bus.i_w = '0;
        bus.i_start = 1'b0;
        bus.i_pix_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({bus.o_w_wr_en, bus.o_w_addr, bus.o_w, bus.o_w_loaded,
              bus.o_pix_ready, bus.o_row, bus.o_col, bus.o_win_valid, bus.o_out_idx,
              bus.o_busy, bus.o_done}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Start in IDLE is ignored
        start_pulse(1'b0);
        $display("txn: start in IDLE ignored");

        load_weights(0, 0);
        $display("txn: back-to-back weight load 0..24");

        run_frame(1'b0, 1'b0);
        $display("txn: full frame, pixels back-to-back");

        load_weights(100, 2);
        $display("txn: gapped weight reload 100..124");

        // Start and a weight word together in READY: RUN entered, word dropped
        bus.i_start = 1'b1;
        bus.i_w_valid = 1'b1;
        bus.i_w = 8'hEE;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        bus.i_w_valid = 1'b0;
        check("start_beats_weight", 64'({bus.o_busy, bus.o_w_loaded}), 64'(3));
        @(posedge clk); #1;
        check("dropped_word_no_strobe", 64'(bus.o_w_wr_en), 64'(0));
        // Finish that pass quietly so the backpressure frame starts from READY
        exp_done++;
        push_windows();
        acc_cnt = 0;
        for (int cyc = 0; cyc < 2000 && bus.o_busy; cyc++) begin
            bus.i_pix_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus.i_pix_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("drop_frame_accepts", 64'(acc_cnt), 64'(IMG * IMG));
        $display("txn: start with weight word in READY");

        run_frame(1'b1, 1'b1);
        $display("txn: backpressured frame with start/weight noise");

        // Reset mid-frame at pixel (10,7)
        exp_done++;
        push_windows();
        bus.i_start = 1'b1;
        bus.i_pix_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_start = 1'b0;
        begin
            bit hit;
            hit = 1'b0;
            for (int cyc = 0; cyc < 2000; cyc++) begin
                @(negedge clk);
                if (bus.o_busy && bus.o_row == 5'd10 && bus.o_col == 5'd7) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("reached_10_7", 64'(hit), 64'(1));
        end
        #1;
        rst_n = 1'b0;
        bus.i_pix_valid = 1'b0;
        winq.delete();
        exp_done = 0;
        @(negedge clk);
        check("midframe_reset_outputs", 64'({bus.o_w_wr_en, bus.o_w_addr, bus.o_w, bus.o_w_loaded,
              bus.o_pix_ready, bus.o_row, bus.o_col, bus.o_win_valid, bus.o_out_idx,
              bus.o_busy, bus.o_done}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_pulse(1'b0);
        $display("txn: reset at (10,7), start ignored afterwards");

        load_weights(50, 0);
        run_frame(1'b0, 1'b0);
        $display("txn: reload and full frame after reset");

        check("final_w_q_empty", 64'(wq.size()), 64'(0));
        check("final_win_q_empty", 64'(winq.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/conv_frame_scheduler.md
Name: conv_frame_scheduler

Overview:
Sequencer for the 5x5 convolution front end.
- Loads the 25 kernel weights into the weight register bank through a write port.
- Once a frame start is received, walks the 32x32 input frame in raster order, pacing pixel acceptance.
- Flags the 28x28 positions where a full kernel window exists, and reports frame completion.
- Sits between the host/stream source and the weight bank plus MAC datapath.

Parameters:
DW, 8, weight data width
K, 5, kernel side; weight count is K*K = 25
IMG, 32, input frame side; output side OUT = IMG-K+1 = 28
WAW, 5, weight address width, equal to $clog2(K*K)
CW, 5, row/column counter width, equal to $clog2(IMG)
OW, 10, output index width, equal to $clog2(OUT*OUT)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  synchronous active-low reset
i_w_valid  in  1  weight word present on i_w
i_w  in  DW  weight data, supplied in order 0..24
o_w_wr_en  out  1  weight bank write strobe
o_w_addr  out  WAW  weight bank address
o_w  out  DW  weight bank write data
o_w_loaded  out  1  all 25 weights written
i_start  in  1  start one frame pass
i_pix_valid  in  1  upstream pixel present
o_pix_ready  out  1  scheduler accepts pixel
o_row  out  CW  row of last accepted pixel
o_col  out  CW  column of last accepted pixel
o_win_valid  out  1  full KxK window ends at last accepted pixel
o_out_idx  out  OW  raster index of current output, 0..783
o_busy  out  1  state is RUN
o_done  out  1  one-cycle pulse, frame finished

Behaviour:
- Reset (sync, i_rst_n=0 at rising edge) forces all outputs to 0, state to IDLE, and all counters to 0. This also applies mid-load and mid-frame; o_w_loaded clears.
- States: IDLE, LOAD, READY, RUN, DONE.
- IDLE:
  - i_w_valid: write word 0; w_cnt=1; go to LOAD.
  - i_start: ignored.
- LOAD: each i_w_valid writes at w_cnt, then w_cnt increments.
  - On the write with w_cnt=K*K-1: go to READY and set o_w_loaded.
  - Cycles without i_w_valid hold state.
  - i_start: ignored.
- Weight write timing: o_w_wr_en, o_w_addr and o_w are registered and appear 1 cycle after i_w_valid. Exactly one strobe per accepted word; never more than 25 per load.
- READY:
  - i_start: go to RUN; row=col=0; o_out_idx=0.
  - i_w_valid (no i_start): reload. Write word 0, w_cnt=1, clear o_w_loaded, go to LOAD.
  - Both asserted in the same cycle: i_start wins and the weight word is dropped.
- RUN:
  - o_pix_ready=1 (combinational from state); o_busy=1.
  - Pixel accepted when i_pix_valid & o_pix_ready. No accept means all counters hold, and o_win_valid is 0 the next cycle.
  - On accept: o_row/o_col take the accepted position one cycle later (registered).
  - On accept: o_win_valid=1 one cycle later iff row>=K-1 and col>=K-1.
  - o_out_idx increments after each cycle with o_win_valid=1. It saturates behaviour-free: the last value is 783.
  - Counter update: col increments; at col=IMG-1, col wraps to 0 and row increments.
  - Accepting pixel (IMG-1, IMG-1) moves to DONE. That pixel's o_win_valid appears in DONE's cycle.
  - i_w_valid and i_start ignored in RUN; weights are never modified mid-frame.
- DONE: one cycle. o_done=1, o_pix_ready=0; next state READY with weights retained. i_start in this cycle is ignored.
- Totals per frame: exactly IMG*IMG = 1024 accepts and OUT*OUT = 784 o_win_valid pulses.
- Latency: i_start to first o_pix_ready is 1 cycle.
- All arithmetic is unsigned; counters never exceed their terminal values.

Decomposition:
- Package conv_pkg holds:
  - state enum (IDLE, LOAD, READY, RUN, DONE);
  - constants K, IMG, OUT, K*K;
  - the derived widths WAW, CW, OW.
- One sub-module is natural: conv_raster_cnt.
  - Holds the row/column counter with enable and wrap.
  - Produces the last-pixel flag and the window-valid compare.
  - Reused later by the output writer.

Test Plan:
- Weight load: 25 back-to-back i_w_valid with i_w=0..24. Expect o_w_wr_en pulses at addr 0..24 carrying data 0..24, each 1 cycle late; o_w_loaded=1 after the 25th; no 26th strobe.
- Gapped load: i_w_valid every 3rd cycle, 25 words. Expect the same address/data sequence; state holds in LOAD between words.
- Full frame: i_start in READY, then i_pix_valid held high. Expect exactly 1024 accepts and 784 o_win_valid pulses. First pulse at (row 4, col 4) with o_out_idx=0; last at (31, 31) with o_out_idx=783; o_done one cycle after the final accept; state returns to READY.
- Backpressure: random 50% i_pix_valid during RUN. Expect 784 o_win_valid pulses and no counter movement on idle cycles; o_win_valid=0 after each idle cycle.
- Ignored events: i_start in IDLE, i_start and i_w_valid during RUN, and i_start together with i_w_valid in READY. Expect no state change in IDLE, no weight strobes in RUN, and RUN entered with the word dropped.
- Reset mid-frame: i_rst_n=0 for one edge at pixel (10, 7). Expect all outputs 0 and state IDLE; o_w_loaded=0; i_start is ignored until 25 new weights are loaded.
